// File: rtl/wb_stage_pipe.sv
// Writeback stage: owns the MEM/WB register, waits on variable-latency load
// data, aligns and extends sub-word loads, and drives the register-file write
// port (also used as the forwarding copy).
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_EMPTY    | nothing to retire, ready to accept
// S_WAIT     | load accepted, waiting for dmem_rvalid_i, memory stage stalled
// S_FULL     | result registered, retiring this cycle, can accept again
module wb_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int SRC_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid_i,
  output logic              m_ready_o,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   pc_plus4_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              reg_write_i,
  input  logic [SRC_W-1:0]  result_src_i,
  input  logic [2:0]        load_f3_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [XLEN-1:0]   rf_wdata_o,
  output logic              retire_o,
  output logic              misalign_o
);

  localparam int LANE_W = $clog2(XLEN / 8);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]        state;
  logic [REG_AW-1:0] ld_rd;
  logic              ld_rw;
  logic [LANE_W-1:0] ld_lane;
  logic [2:0]        ld_f3;

  logic              accept;
  logic              is_load;
  logic [XLEN-1:0]   nl_val;
  logic [XLEN-1:0]   ld_shift;
  logic [XLEN-1:0]   ld_val;
  logic              ld_fault;

  assign m_ready_o = (state != S_WAIT);
  assign accept    = m_valid_i & m_ready_o;
  assign is_load   = (result_src_i == SRC_W'(1));

  // Result mux for instructions that retire without waiting on memory.
  always_comb begin
    nl_val = '0;
    case (result_src_i)
      SRC_W'(0): nl_val = alu_result_i;
      SRC_W'(2): nl_val = pc_plus4_i;
      SRC_W'(3): nl_val = imm_i;
      default:   nl_val = '0;
    endcase
  end

  // Lane alignment, extension and fault detection for returning load data.
  // A faulting load retires with zero data so nothing stale is forwarded.
  always_comb begin
    ld_shift = dmem_rdata_i >> {ld_lane, 3'b000};
    ld_val   = '0;
    ld_fault = 1'b0;
    case (ld_f3)
      3'd0: ld_val = XLEN'($signed(ld_shift[7:0]));
      3'd1: begin
        ld_val   = XLEN'($signed(ld_shift[15:0]));
        ld_fault = ld_lane[0];
      end
      3'd2: begin
        ld_val   = XLEN'($signed(ld_shift[31:0]));
        ld_fault = (ld_lane[1:0] != 2'b00);
      end
      3'd3: begin
        if (XLEN == 64) begin
          ld_val   = ld_shift;
          ld_fault = (ld_lane != '0);
        end else begin
          ld_fault = 1'b1;
        end
      end
      3'd4: ld_val = XLEN'(ld_shift[7:0]);
      3'd5: begin
        ld_val   = XLEN'(ld_shift[15:0]);
        ld_fault = ld_lane[0];
      end
      3'd6: begin
        if (XLEN == 64) begin
          ld_val   = XLEN'(ld_shift[31:0]);
          ld_fault = (ld_lane[1:0] != 2'b00);
        end else begin
          ld_fault = 1'b1;
        end
      end
      default: ld_fault = 1'b1;
    endcase
    if (ld_fault) ld_val = '0;
  end

  // State machine; the retire outputs are registered on entry to S_FULL so
  // they are valid for exactly the S_FULL cycle and the write data holds after.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_EMPTY;
      ld_rd      <= '0;
      ld_rw      <= 1'b0;
      ld_lane    <= '0;
      ld_f3      <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      retire_o   <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      rf_we_o    <= 1'b0;
      retire_o   <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        S_EMPTY, S_FULL: begin
          if (accept && is_load) begin
            state   <= S_WAIT;
            ld_rd   <= rd_i;
            ld_rw   <= reg_write_i;
            ld_lane <= alu_result_i[LANE_W-1:0];
            ld_f3   <= load_f3_i;
          end else if (accept) begin
            state      <= S_FULL;
            rf_we_o    <= reg_write_i & (rd_i != '0);
            rf_waddr_o <= rd_i;
            rf_wdata_o <= nl_val;
            retire_o   <= 1'b1;
          end else begin
            state <= S_EMPTY;
          end
        end
        S_WAIT: begin
          if (dmem_rvalid_i) begin
            state      <= S_FULL;
            rf_we_o    <= ld_rw & (ld_rd != '0) & ~ld_fault;
            rf_waddr_o <= ld_rd;
            rf_wdata_o <= ld_val;
            retire_o   <= 1'b1;
            misalign_o <= ld_fault;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: directed cases plus randomized non-load and load
// streams checked against a transaction-level reference model.
module tb_wb_stage_pipe;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int SRC_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              m_valid_i;
  logic              m_ready_o;
  logic [XLEN-1:0]   alu_result_i;
  logic [XLEN-1:0]   pc_plus4_i;
  logic [XLEN-1:0]   imm_i;
  logic [REG_AW-1:0] rd_i;
  logic              reg_write_i;
  logic [SRC_W-1:0]  result_src_i;
  logic [2:0]        load_f3_i;
  logic              dmem_rvalid_i;
  logic [XLEN-1:0]   dmem_rdata_i;
  logic              rf_we_o;
  logic [REG_AW-1:0] rf_waddr_o;
  logic [XLEN-1:0]   rf_wdata_o;
  logic              retire_o;
  logic              misalign_o;

  typedef logic [REG_AW+XLEN+2:0] obs_t;
  obs_t obs;
  assign obs = {rf_we_o, rf_waddr_o, rf_wdata_o, retire_o, misalign_o};

  int n_cmp = 0;
  int n_err = 0;
  logic [REG_AW-1:0] last_waddr;
  logic [XLEN-1:0]   last_wdata;

  wb_stage_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .SRC_W(SRC_W)) dut (
    .clk(clk), .rst(rst), .m_valid_i(m_valid_i), .m_ready_o(m_ready_o),
    .alu_result_i(alu_result_i), .pc_plus4_i(pc_plus4_i), .imm_i(imm_i),
    .rd_i(rd_i), .reg_write_i(reg_write_i), .result_src_i(result_src_i),
    .load_f3_i(load_f3_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .retire_o(retire_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running exp finished");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_nonload(int src, logic [XLEN-1:0] alu,
                                                  logic [XLEN-1:0] pc4, logic [XLEN-1:0] imm);
    case (src)
      0: return alu;
      2: return pc4;
      3: return imm;
      default: return '0;
    endcase
  endfunction

  function automatic void ref_load(input int f3, input logic [XLEN-1:0] addr,
                                   input logic [XLEN-1:0] rdata,
                                   output logic [XLEN-1:0] val, output bit fault);
    int lane;
    longint unsigned sh, b, h;
    lane  = int'(addr % 4);
    sh    = longint'(rdata) / (64'd1 << (8 * lane));
    b     = sh % 256;
    h     = sh % 65536;
    fault = 1'b0;
    val   = '0;
    case (f3)
      0: val = (b >= 128) ? 32'(longint'(b) - 256) : 32'(b);
      1: if (lane % 2 != 0) fault = 1'b1;
         else val = (h >= 32768) ? 32'(longint'(h) - 65536) : 32'(h);
      2: if (lane != 0) fault = 1'b1; else val = rdata;
      4: val = 32'(b);
      5: if (lane % 2 != 0) fault = 1'b1; else val = 32'(h);
      default: fault = 1'b1;
    endcase
    if (fault) val = '0;
  endfunction

  function automatic obs_t pack(logic we, logic [REG_AW-1:0] a, logic [XLEN-1:0] d,
                                logic ret, logic mis);
    return {we, a, d, ret, mis};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m_valid_i = 1'b0; alu_result_i = '0; pc_plus4_i = '0; imm_i = '0;
    rd_i = '0; reg_write_i = 1'b0; result_src_i = '0; load_f3_i = '0;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
  endtask

  task automatic drive_nl(logic v, int src, logic [XLEN-1:0] alu, logic [XLEN-1:0] pc4,
                          logic [XLEN-1:0] imm, logic [REG_AW-1:0] rd, logic rw);
    m_valid_i = v; result_src_i = SRC_W'(src); alu_result_i = alu;
    pc_plus4_i = pc4; imm_i = imm; rd_i = rd; reg_write_i = rw;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    n_cmp++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %h exp %h", obs, obs_t'(0));
    end
    rst = 1'b0;
    n_cmp++;
    if (m_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready got %b exp 1", m_ready_o);
    end
    last_waddr = '0;
    last_wdata = '0;
  endtask

  task automatic test_alu();
    obs_t e;
    drive_nl(1'b1, 0, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1'b1);
    tick();
    m_valid_i = 1'b0;
    e = pack(1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL alu_write got %h exp %h", obs, e); end
    tick();
    e = pack(1'b0, 5'd5, 32'h0000_1234, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL alu_hold got %h exp %h", obs, e); end
    last_waddr = 5'd5;
    last_wdata = 32'h0000_1234;
  endtask

  task automatic test_back_to_back();
    obs_t e;
    drive_nl(1'b1, 2, 32'h0, 32'h0000_0104, 32'h0, 5'd1, 1'b1);
    tick();
    e = pack(1'b1, 5'd1, 32'h0000_0104, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== e || m_ready_o !== 1'b1) begin
      n_err++; $display("FAIL b2b_first got %h rdy %b exp %h rdy 1", obs, m_ready_o, e);
    end
    drive_nl(1'b1, 3, 32'h0, 32'h0, 32'hABCD_E000, 5'd2, 1'b1);
    tick();
    m_valid_i = 1'b0;
    e = pack(1'b1, 5'd2, 32'hABCD_E000, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== e || m_ready_o !== 1'b1) begin
      n_err++; $display("FAIL b2b_second got %h rdy %b exp %h rdy 1", obs, m_ready_o, e);
    end
    last_waddr = 5'd2;
    last_wdata = 32'hABCD_E000;
  endtask

  task automatic test_rd_zero();
    obs_t e;
    drive_nl(1'b1, 0, 32'h0000_DEAD, 32'h0, 32'h0, 5'd0, 1'b1);
    tick();
    m_valid_i = 1'b0;
    e = pack(1'b0, 5'd0, 32'h0000_DEAD, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL rd_zero got %h exp %h", obs, e); end
    last_waddr = 5'd0;
    last_wdata = 32'h0000_DEAD;
  endtask

  task automatic test_random_nonload();
    obs_t e;
    for (int i = 0; i < 40; i++) begin
      logic v, rw;
      int s, src;
      logic [XLEN-1:0] a, p, m;
      logic [REG_AW-1:0] rd;
      v   = ($urandom_range(0, 4) != 0);
      s   = $urandom_range(0, 2);
      src = (s == 0) ? 0 : s + 1;
      a = $urandom; p = $urandom; m = $urandom;
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : REG_AW'($urandom);
      rw = 1'($urandom);
      drive_nl(v, src, a, p, m, rd, rw);
      n_cmp++;
      if (m_ready_o !== 1'b1) begin
        n_err++; $display("FAIL rnd_nl_ready[%0d] got %b exp 1", i, m_ready_o);
      end
      tick();
      if (v) begin
        last_waddr = rd;
        last_wdata = ref_nonload(src, a, p, m);
        e = pack(rw && (rd != 0), last_waddr, last_wdata, 1'b1, 1'b0);
      end else begin
        e = pack(1'b0, last_waddr, last_wdata, 1'b0, 1'b0);
      end
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL rnd_nl[%0d] got %h exp %h", i, obs, e); end
    end
    m_valid_i = 1'b0;
  endtask

  // Accept one load, stall `delay` cycles (rvalid lands on the last one),
  // and check the stall and the retired result.
  task automatic do_load(string name, int f3, logic [XLEN-1:0] addr, logic [XLEN-1:0] rdata,
                         logic [REG_AW-1:0] rd, logic rw, int delay);
    obs_t e;
    logic [XLEN-1:0] val;
    bit fault;
    m_valid_i = 1'b1; result_src_i = SRC_W'(1); alu_result_i = addr;
    load_f3_i = 3'(f3); rd_i = rd; reg_write_i = rw;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = ~rdata;
    tick();
    m_valid_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
    for (int i = 0; i < delay; i++) begin
      e = pack(1'b0, last_waddr, last_wdata, 1'b0, 1'b0);
      n_cmp++;
      if (m_ready_o !== 1'b0 || obs !== e) begin
        n_err++;
        $display("FAIL %s_stall[%0d] got rdy %b %h exp rdy 0 %h", name, i, m_ready_o, obs, e);
      end
      if (i < delay - 1) tick();
    end
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
    tick();
    dmem_rvalid_i = 1'b0;
    ref_load(f3, addr, rdata, val, fault);
    last_waddr = rd;
    last_wdata = val;
    e = pack(rw && (rd != 0) && !fault, rd, val, 1'b1, fault);
    n_cmp++;
    if (obs !== e || m_ready_o !== 1'b1) begin
      n_err++; $display("FAIL %s_result got %h rdy %b exp %h rdy 1", name, obs, m_ready_o, e);
    end
  endtask

  task automatic test_load_directed();
    do_load("lb",  0, 32'h0000_1003, 32'h80FF_0000, 5'd9,  1'b1, 3);
    do_load("lbu", 4, 32'h0000_1003, 32'h80FF_0000, 5'd10, 1'b1, 3);
    do_load("lhu", 5, 32'h0000_1002, 32'h80FF_0000, 5'd11, 1'b1, 2);
    do_load("lw",  2, 32'h0000_2000, 32'h1234_5678, 5'd12, 1'b1, 1);
    do_load("misalign_lw", 2, 32'h0000_2002, 32'h1234_5678, 5'd7, 1'b1, 1);
  endtask

  task automatic test_random_load();
    for (int i = 0; i < 30; i++) begin
      do_load("rnd_ld", $urandom_range(0, 7), $urandom, $urandom,
              REG_AW'($urandom), 1'($urandom), $urandom_range(1, 4));
    end
  endtask

  task automatic test_reset_mid_load();
    m_valid_i = 1'b1; result_src_i = SRC_W'(1); alu_result_i = 32'h0000_3000;
    load_f3_i = 3'd2; rd_i = 5'd4; reg_write_i = 1'b1;
    tick();
    m_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL rst_mid_outputs got %h exp %h", obs, obs_t'(0)); end
    rst = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    n_cmp++;
    if (m_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready got %b exp 1", m_ready_o); end
    tick();
    dmem_rvalid_i = 1'b0;
    n_cmp++;
    if (obs !== '0 || m_ready_o !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_rvalid got %h rdy %b exp %h rdy 1", obs, m_ready_o, obs_t'(0));
    end
    last_waddr = '0;
    last_wdata = '0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_rd_zero();
    test_load_directed();
    test_random_nonload();
    test_random_load();
    test_reset_mid_load();
    test_alu();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
